result_bcd_formatter: RTL and testbench

Downstream stage of the calculator ALU add/sub block: captures one ALU result and converts it to sign plus three BCD digits for the seven-segment display driver. Signed magnitude is derived from the ALU's sum, carry-out, operation select and less-than flag. Conversion runs as a sequential shift-add-3 (double-dabble) engine, one bit per cycle. Valid/ready handshakes sit on both sides.

---
 rtl/result_bcd_formatter.sv | 170 +++++++++++++++++
 tb/tb_result_bcd_formatter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/result_bcd_formatter.sv
// rtl/result_bcd_formatter.sv - ALU result to sign + 3-digit BCD, serial double-dabble
// Optional macro BCD_LEADING_BLANK_EN: leading-zero digits presented as 4'hF (blank).
module result_bcd_formatter (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] Sum,
    input  logic       C_8,
    input  logic       Add_Sub,
    input  logic       ALB,
    input  logic       In_Valid,
    output logic       In_Ready,
    output logic       Out_Valid,
    input  logic       Out_Ready,
    output logic       Neg,
    output logic [3:0] Hund,
    output logic [3:0] Tens,
    output logic [3:0] Ones
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [8:0]  r_mag;
    logic [11:0] r_bcd;
    logic [3:0]  r_cnt;
    logic        r_neg_cap;
    logic        r_out_valid;
    logic        r_neg;
    logic [3:0]  r_hund;
    logic [3:0]  r_tens;
    logic [3:0]  r_ones;

    logic        w_accept;
    logic        w_last;
    logic        w_release;
    logic [7:0]  w_sum_twos;
    logic [8:0]  w_mag_load;
    logic        w_neg_load;
    logic [3:0]  w_adj_hund;
    logic [3:0]  w_adj_tens;
    logic [3:0]  w_adj_ones;
    logic [11:0] w_bcd_next;
    logic [8:0]  w_mag_next;
    logic [3:0]  w_hund_disp;
    logic [3:0]  w_tens_disp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        w_release    = 1'b0;
        In_Ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                In_Ready = 1'b1;
                if (In_Valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_CONV;
                end
            end
            S_CONV: begin
                if (r_cnt == 4'd8) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (Out_Ready) begin
                    w_release    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Subtraction with A<B leaves a two's-complement Sum; negate it to get |A-B|.
    always_comb begin
        w_sum_twos = ~Sum + 8'd1;
        w_mag_load = {C_8, Sum};
        w_neg_load = 1'b0;
        if (Add_Sub) begin
            if (ALB) begin
                w_mag_load = {1'b0, w_sum_twos};
                w_neg_load = 1'b1;
            end else begin
                w_mag_load = {1'b0, Sum};
            end
        end
    end

    always_comb begin
        w_adj_ones = (r_bcd[3:0]  >= 4'd5) ? r_bcd[3:0]  + 4'd3 : r_bcd[3:0];
        w_adj_tens = (r_bcd[7:4]  >= 4'd5) ? r_bcd[7:4]  + 4'd3 : r_bcd[7:4];
        w_adj_hund = (r_bcd[11:8] >= 4'd5) ? r_bcd[11:8] + 4'd3 : r_bcd[11:8];
        w_bcd_next = {w_adj_hund[2:0], w_adj_tens, w_adj_ones, r_mag[8]};
        w_mag_next = {r_mag[7:0], 1'b0};
    end

`ifdef BCD_LEADING_BLANK_EN
    always_comb begin
        w_hund_disp = (w_bcd_next[11:8] == 4'd0) ? 4'hF : w_bcd_next[11:8];
        w_tens_disp = ((w_bcd_next[11:8] == 4'd0) && (w_bcd_next[7:4] == 4'd0))
                      ? 4'hF : w_bcd_next[7:4];
    end
`else
    always_comb begin
        w_hund_disp = w_bcd_next[11:8];
        w_tens_disp = w_bcd_next[7:4];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mag     <= 9'd0;
            r_bcd     <= 12'd0;
            r_cnt     <= 4'd0;
            r_neg_cap <= 1'b0;
        end else if (w_accept) begin
            r_mag     <= w_mag_load;
            r_bcd     <= 12'd0;
            r_cnt     <= 4'd0;
            r_neg_cap <= w_neg_load;
        end else if (r_state == S_CONV) begin
            r_mag <= w_mag_next;
            r_bcd <= w_bcd_next;
            r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
        end
    end

    // Visible result only changes on the final iteration edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_neg       <= 1'b0;
            r_hund      <= 4'd0;
            r_tens      <= 4'd0;
            r_ones      <= 4'd0;
        end else if (w_last) begin
            r_out_valid <= 1'b1;
            r_neg       <= r_neg_cap;
            r_hund      <= w_hund_disp;
            r_tens      <= w_tens_disp;
            r_ones      <= w_bcd_next[3:0];
        end else if (w_release) begin
            r_out_valid <= 1'b0;
        end
    end

    assign Out_Valid = r_out_valid;
    assign Neg       = r_neg;
    assign Hund      = r_hund;
    assign Tens      = r_tens;
    assign Ones      = r_ones;

endmodule

// File: tb/tb_result_bcd_formatter.sv
// tb/tb_result_bcd_formatter.sv - scoreboard bench for result_bcd_formatter
module tb_result_bcd_formatter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] Sum;
    logic       C_8;
    logic       Add_Sub;
    logic       ALB;
    logic       In_Valid;
    logic       In_Ready;
    logic       Out_Valid;
    logic       Out_Ready;
    logic       Neg;
    logic [3:0] Hund;
    logic [3:0] Tens;
    logic [3:0] Ones;

    int total = 0;
    int bad   = 0;
    logic [12:0] exp_q[$];

    result_bcd_formatter dut (
        .clk(clk), .rst(rst), .Sum(Sum), .C_8(C_8), .Add_Sub(Add_Sub), .ALB(ALB),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready), .Neg(Neg), .Hund(Hund), .Tens(Tens), .Ones(Ones)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] fmt(input logic n, input logic [3:0] h, input logic [3:0] t,
                                        input logic [3:0] o);
        logic [3:0] hh;
        logic [3:0] tt;
        hh = h;
        tt = t;
`ifdef BCD_LEADING_BLANK_EN
        if (h == 4'd0) hh = 4'hF;
        if (h == 4'd0 && t == 4'd0) tt = 4'hF;
`endif
        return {n, hh, tt, o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && Out_Valid && Out_Ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got %0h expected none", {Neg, Hund, Tens, Ones});
            end else begin
                logic [12:0] e;
                e = exp_q.pop_front();
                check("result", {19'd0, Neg, Hund, Tens, Ones}, {19'd0, e});
            end
        end
    end

    task automatic run(input logic [7:0] s, input logic c, input logic as, input logic lt,
                       input logic [12:0] e);
        int n;
        n = 0;
        while (!In_Ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_before", In_Ready, 1);
        Sum = s; C_8 = c; Add_Sub = as; ALB = lt; In_Valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        In_Valid = 1'b0;
        check("in_ready_conv", In_Ready, 0);
        n = 0;
        while (!Out_Valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, 9);
        if (Out_Ready) begin
            @(posedge clk); #1;
            check("release_in_ready", In_Ready, 1);
            check("release_out_valid", Out_Valid, 0);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; Sum = 8'd0; C_8 = 1'b0; Add_Sub = 1'b0; ALB = 1'b0;
        In_Valid = 1'b0; Out_Ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_in_ready", In_Ready, 1);
        check("reset_out_valid", Out_Valid, 0);
        check("reset_outputs", {Neg, Hund, Tens, Ones}, 0);

        run(8'h2C, 1'b1, 1'b0, 1'b0, fmt(1'b0, 4'd3, 4'd0, 4'd0));   // 200+100
        run(8'hF1, 1'b0, 1'b1, 1'b1, fmt(1'b1, 4'd0, 4'd1, 4'd5));   // 5-20
        run(8'hFE, 1'b1, 1'b0, 1'b0, fmt(1'b0, 4'd5, 4'd1, 4'd0));   // 255+255
        run(8'h01, 1'b0, 1'b1, 1'b1, fmt(1'b1, 4'd2, 4'd5, 4'd5));   // 0-255
        run(8'h00, 1'b0, 1'b1, 1'b0, fmt(1'b0, 4'd0, 4'd0, 4'd0));   // 7-7
        run(8'h09, 1'b0, 1'b0, 1'b0, fmt(1'b0, 4'd0, 4'd0, 4'd9));   // 9+0
        run(8'h2A, 1'b0, 1'b1, 1'b0, fmt(1'b0, 4'd0, 4'd4, 4'd2));   // 50-8

        // Backpressure: hold DONE with a competing In_Valid.
        Out_Ready = 1'b0;
        run(8'h80, 1'b0, 1'b0, 1'b0, fmt(1'b0, 4'd1, 4'd2, 4'd8));   // 128+0
        Sum = 8'h55; C_8 = 1'b1; Add_Sub = 1'b0; ALB = 1'b0; In_Valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", Out_Valid, 1);
            check("bp_in_ready", In_Ready, 0);
            check("bp_hold", {Neg, Hund, Tens, Ones}, fmt(1'b0, 4'd1, 4'd2, 4'd8));
        end
        In_Valid = 1'b0;
        Out_Ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", In_Ready, 1);
        check("bp_release_out_valid", Out_Valid, 0);
        repeat (12) @(posedge clk);
        #1 check("bp_no_spurious", Out_Valid, 0);
        run(8'h80, 1'b0, 1'b1, 1'b1, fmt(1'b1, 4'd1, 4'd2, 4'd8));   // 0-128

        // Reset at iteration 4 discards the in-flight 200+100.
        Sum = 8'h2C; C_8 = 1'b1; Add_Sub = 1'b0; ALB = 1'b0; In_Valid = 1'b1;
        @(posedge clk); #1;
        In_Valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_in_ready", In_Ready, 1);
        check("rst_mid_out_valid", Out_Valid, 0);
        check("rst_mid_outputs", {Neg, Hund, Tens, Ones}, 0);
        run(8'h7B, 1'b0, 1'b0, 1'b0, fmt(1'b0, 4'd1, 4'd2, 4'd3));   // 100+23

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
